hilo_mult_unit: RTL and testbench

HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

---
 rtl/hilo_mult_unit.sv | 215 +++++++++++++++++++++
 tb/tb_hilo_mult_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_unit.sv
// -----------------------------------------------------------------------------
// hilo_mult_unit
//
// Iterative MIPS-style multiply unit owning the architectural HI/LO pair.
// Multicycle ops (mult, multu, mul, and optionally madd/msub) run a radix
// 2^BITS_PER_CYCLE shift-add over operand magnitudes for N = 32/BITS_PER_CYCLE
// cycles, then fix the sign and write back in a single FIN cycle. mthi/mtlo
// write HI/LO directly in one cycle; mfhi/mflo are pure combinational reads
// on Result.
//
// Optional feature: define MADD_MSUB_EN to enable madd (16) / msub (17).
// When undefined those codes are ignored and the accumulate adders are absent.
//
// Parameters:
//   BITS_PER_CYCLE  product bits retired per BUSY cycle (1, 2 or 4)
//
// Ports:
//   Clk      in   1   rising-edge clock
//   Rst      in   1   synchronous active-high reset
//   Start    in   1   op valid from EX stage this cycle
//   ALUCtrl  in   6   op code (4 mult, 24 multu, 16 madd, 17 msub, 8 mul,
//                     30 mthi, 29 mtlo, 31 mfhi, 23 mflo)
//   A, B     in   32  operands (rs, rt)
//   Stall    out  1   pipeline hold request
//   Done     out  1   one-cycle completion pulse (FIN cycle)
//   Result   out  32  write-back value for mfhi / mflo / mul
//   HI, LO   out  32  architectural HI/LO registers
// -----------------------------------------------------------------------------
module hilo_mult_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [5:0]  ALUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int N = 32 / BITS_PER_CYCLE;

  localparam logic [5:0] CODE_MULT  = 6'd4;
  localparam logic [5:0] CODE_MULTU = 6'd24;
  localparam logic [5:0] CODE_MADD  = 6'd16;
  localparam logic [5:0] CODE_MSUB  = 6'd17;
  localparam logic [5:0] CODE_MUL   = 6'd8;
  localparam logic [5:0] CODE_MTHI  = 6'd30;
  localparam logic [5:0] CODE_MTLO  = 6'd29;
  localparam logic [5:0] CODE_MFHI  = 6'd31;
  localparam logic [5:0] CODE_MFLO  = 6'd23;

  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MADD, OP_MSUB, OP_MUL} op_t;

  state_t      state;
  op_t         op;
  logic        neg;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [31:0] mul_res;

  // ---------------------------------------------------------------------------
  // Op decode: which codes start a multicycle op, and how.
  // ---------------------------------------------------------------------------
  logic is_multi;
  logic is_signed;
  op_t  op_dec;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    is_multi  = 1'b0;
    is_signed = 1'b1;
    op_dec    = OP_MULT;
    case (ALUCtrl)
      CODE_MULT:  is_multi = 1'b1;
      CODE_MULTU: begin
        is_multi  = 1'b1;
        is_signed = 1'b0;
      end
`ifdef MADD_MSUB_EN
      CODE_MADD: begin
        is_multi = 1'b1;
        op_dec   = OP_MADD;
      end
      CODE_MSUB: begin
        is_multi = 1'b1;
        op_dec   = OP_MSUB;
      end
`endif
      CODE_MUL: begin
        is_multi = 1'b1;
        op_dec   = OP_MUL;
      end
      default: ;
    endcase
  end

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31 once zero-extended into the 64-bit path.
  logic [31:0] a_mag, b_mag;
  assign a_mag = (is_signed && A[31]) ? (~A + 32'd1) : A;
  assign b_mag = (is_signed && B[31]) ? (~B + 32'd1) : B;

  // Stall covers the whole op, including the issue cycle before the FSM moves.
  assign Stall = (state != IDLE) || (Start && is_multi);

  // ---------------------------------------------------------------------------
  // Partial product for one iteration: multiplicand times the low
  // BITS_PER_CYCLE multiplier bits, built from shifted adds.
  // ---------------------------------------------------------------------------
  logic [63:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
  end

  // Sign fix-up applied in FIN once the magnitude product is complete.
  logic [63:0] final_prod;
  assign final_prod = neg ? (~acc + 64'd1) : acc;

`ifdef MADD_MSUB_EN
  logic [63:0] hilo_sum;
  logic [63:0] hilo_diff;
  assign hilo_sum  = {HI, LO} + final_prod;
  assign hilo_diff = {HI, LO} - final_prod;
`endif

  // ---------------------------------------------------------------------------
  // FSM and datapath registers. Done is registered: set on the BUSY->FIN
  // edge so it is high for exactly the FIN cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      state   <= IDLE;
      op      <= OP_MULT;
      neg     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mul_res <= '0;
      HI      <= '0;
      LO      <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (is_multi) begin
              acc    <= '0;
              mcand  <= {32'd0, a_mag};
              mplier <= b_mag;
              neg    <= is_signed && (A[31] ^ B[31]);
              op     <= op_dec;
              cnt    <= 6'(N - 1);
              state  <= BUSY;
            end else if (ALUCtrl == CODE_MTHI) begin
              HI <= A;
            end else if (ALUCtrl == CODE_MTLO) begin
              LO <= A;
            end
          end
        end

        BUSY: begin
          acc    <= acc + pp;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          if (cnt == 6'd0) begin
            state <= FIN;
            Done  <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end

        FIN: begin
          case (op)
            OP_MUL: mul_res <= final_prod[31:0];
`ifdef MADD_MSUB_EN
            OP_MADD: {HI, LO} <= hilo_sum;
            OP_MSUB: {HI, LO} <= hilo_diff;
`endif
            default: {HI, LO} <= final_prod;
          endcase
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Read port: mfhi/mflo need no Start and see HI/LO as currently committed.
  always_comb begin
    Result = mul_res;
    if (ALUCtrl == CODE_MFHI)      Result = HI;
    else if (ALUCtrl == CODE_MFLO) Result = LO;
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_mult_unit
//
// Scoreboard bench for hilo_mult_unit. The driver issues ops and pushes the
// expected HI/LO/Result (from a plain 64-bit arithmetic model) into a queue;
// a monitor pops an entry on each Done pulse and checks completion timing and
// the committed values one cycle later. Directed cases cover reset, the
// worked examples, abort and ignored-Start; a randomized loop follows.
// -----------------------------------------------------------------------------
module tb_hilo_mult_unit;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;

  localparam logic [5:0] C_MULT  = 6'd4;
  localparam logic [5:0] C_MULTU = 6'd24;
  localparam logic [5:0] C_MADD  = 6'd16;
  localparam logic [5:0] C_MSUB  = 6'd17;
  localparam logic [5:0] C_MUL   = 6'd8;
  localparam logic [5:0] C_MTHI  = 6'd30;
  localparam logic [5:0] C_MTLO  = 6'd29;
  localparam logic [5:0] C_MFHI  = 6'd31;
  localparam logic [5:0] C_MFLO  = 6'd23;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [5:0]  ALUCtrl;
  logic [31:0] A, B;
  logic        Stall, Done;
  logic [31:0] Result, HI, LO;

  hilo_mult_unit #(.BITS_PER_CYCLE(BPC)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .ALUCtrl (ALUCtrl),
    .A       (A),
    .B       (B),
    .Stall   (Stall),
    .Done    (Done),
    .Result  (Result),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
    int unsigned issue;
  } exp_t;

  exp_t sb[$];

  // Architectural model state.
  logic [31:0] hi_m  = '0;
  logic [31:0] lo_m  = '0;
  logic [31:0] mul_m = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops on Done, checks timing, then checks commit on the next cycle.
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        check("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.issue + N + 1));
          @(posedge Clk);
          #1;
          check("commit_hi", 64'(HI), 64'(e.hi));
          check("commit_lo", 64'(LO), 64'(e.lo));
          check("commit_result", 64'(Result), 64'(e.res));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge Clk);
    #1;
    Start   = 1'b0;
    ALUCtrl = 6'd0;
  endtask

  task automatic start_op(input logic [5:0] code, input logic [31:0] x, input logic [31:0] y,
                          input bit expect_done);
    logic [63:0] p;
    p = ref_prod(code != C_MULTU, x, y);
    @(posedge Clk);
    #1;
    Start   = 1'b1;
    ALUCtrl = code;
    A       = x;
    B       = y;
    if (expect_done) begin
      case (code)
        C_MADD:  {hi_m, lo_m} = {hi_m, lo_m} + p;
        C_MSUB:  {hi_m, lo_m} = {hi_m, lo_m} - p;
        C_MUL:   mul_m = p[31:0];
        default: {hi_m, lo_m} = p;
      endcase
      sb.push_back('{hi: hi_m, lo: lo_m, res: mul_m, issue: cyc});
    end
    #1;
    check("stall_issue_cycle", 64'(Stall), 64'd1);
  endtask

  // Runs the op to completion; 'already' counts stall cycles seen so far.
  task automatic finish_op(input int already);
    int n;
    n = already;
    step();
    while (Stall === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("stall_cycles", 64'(n), 64'(N + 1));
  endtask

  task automatic mc_op(input logic [5:0] code, input logic [31:0] x, input logic [31:0] y);
    start_op(code, x, y, 1'b1);
    finish_op(0);
  endtask

  task automatic mt_op(input logic [5:0] code, input logic [31:0] x);
    @(posedge Clk);
    #1;
    Start   = 1'b1;
    ALUCtrl = code;
    A       = x;
    #1;
    check("mt_no_stall", 64'(Stall), 64'd0);
    if (code == C_MTHI) hi_m = x;
    else                lo_m = x;
    step();
    check("mt_hi", 64'(HI), 64'(hi_m));
    check("mt_lo", 64'(LO), 64'(lo_m));
  endtask

  // Any code that must leave the unit untouched.
  task automatic nop_op(input logic [5:0] code, input logic [31:0] x, input logic [31:0] y);
    @(posedge Clk);
    #1;
    Start   = 1'b1;
    ALUCtrl = code;
    A       = x;
    B       = y;
    #1;
    check("nop_no_stall", 64'(Stall), 64'd0);
    step();
    step();
    check("nop_stall_after", 64'(Stall), 64'd0);
    check("nop_hi", 64'(HI), 64'(hi_m));
    check("nop_lo", 64'(LO), 64'(lo_m));
  endtask

  task automatic read_op();
    @(posedge Clk);
    #1;
    ALUCtrl = C_MFHI;
    #1;
    check("mfhi", 64'(Result), 64'(hi_m));
    ALUCtrl = C_MFLO;
    #1;
    check("mflo", 64'(Result), 64'(lo_m));
    ALUCtrl = 6'd0;
    #1;
    check("mul_result_idle", 64'(Result), 64'(mul_m));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] pre_hi, pre_lo;
    Rst = 1'b1; Start = 1'b0; ALUCtrl = 6'd0; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_result", 64'(Result), 64'd0);
    Rst = 1'b0;

    // Worked examples.
    mc_op(C_MULT, 32'hFFFF_FFFD, 32'd7);
    check("ex_mult_hi", 64'(hi_m), 64'hFFFF_FFFF);
    check("ex_mult_lo", 64'(lo_m), 64'hFFFF_FFEB);
    mc_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mc_op(C_MUL, 32'hFFFF_FFFB, 32'd6);
    check("ex_mul_res", 64'(mul_m), 64'hFFFF_FFE2);
    mc_op(C_MULT, 32'h8000_0000, 32'h8000_0000);
    mc_op(C_MULT, 32'h8000_0000, 32'd1);
    read_op();

    mt_op(C_MTHI, 32'd1);
    mt_op(C_MTLO, 32'd8);
`ifdef MADD_MSUB_EN
    mc_op(C_MADD, 32'd2, 32'd3);
    check("ex_madd_lo", 64'(lo_m), 64'h0000_000E);
    mc_op(C_MSUB, 32'd4, 32'd4);
    check("ex_msub_hi", 64'(hi_m), 64'h0);
    check("ex_msub_lo", 64'(lo_m), 64'hFFFF_FFFE);
`else
    nop_op(C_MADD, 32'd2, 32'd3);
    nop_op(C_MSUB, 32'd4, 32'd4);
`endif
    nop_op(6'd5, 32'h1234, 32'h5678);

    // mfhi/mflo during an op read the pre-op HI/LO.
    mt_op(C_MTHI, 32'h0000_1234);
    mt_op(C_MTLO, 32'h0000_5678);
    pre_hi = hi_m;
    pre_lo = lo_m;
    start_op(C_MULT, 32'd5, 32'd7, 1'b1);
    repeat (3) step();
    ALUCtrl = C_MFHI;
    #1;
    check("mfhi_during_busy", 64'(Result), 64'(pre_hi));
    ALUCtrl = C_MFLO;
    #1;
    check("mflo_during_busy", 64'(Result), 64'(pre_lo));
    ALUCtrl = 6'd0;
    finish_op(3);

    // Reset in cycle 10 of a mult aborts it with no Done.
    start_op(C_MULT, 32'd9, 32'd9, 1'b0);
    repeat (9) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    #1;
    hi_m = '0; lo_m = '0; mul_m = '0;
    check("abort_stall", 64'(Stall), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    repeat (N + 8) step();
    check("abort_lo_later", 64'(LO), 64'd0);

    // mthi issued in cycle 5 of a mult is ignored.
    start_op(C_MULT, 32'd2, 32'd3, 1'b1);
    repeat (4) step();
    @(posedge Clk);
    #1;
    Start   = 1'b1;
    ALUCtrl = C_MTHI;
    A       = 32'h55;
    #1;
    check("ignored_start_stall", 64'(Stall), 64'd1);
    finish_op(5);
    check("ignored_model_hi", 64'(hi_m), 64'd0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = rand_operand();
      y = rand_operand();
      case ($urandom_range(0, 8))
        0: mc_op(C_MULT, x, y);
        1: mc_op(C_MULTU, x, y);
        2: mc_op(C_MUL, x, y);
`ifdef MADD_MSUB_EN
        3: mc_op(C_MADD, x, y);
        4: mc_op(C_MSUB, x, y);
`else
        3: nop_op(C_MADD, x, y);
        4: nop_op(C_MSUB, x, y);
`endif
        5: mt_op(C_MTHI, x);
        6: mt_op(C_MTLO, x);
        7: read_op();
        default: nop_op(6'($urandom_range(0, 3)), x, y);
      endcase
    end

    repeat (5) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
